// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and sync decode shared by the sync generator and pixel stages
//    No ports. Provides horizontal/vertical active, porch, sync and total
//    counts, the 10-bit compare points derived from them, and decode_sync(),
//    which maps a (x, y) position onto the active-low syncs and video_on.
package vga_timing_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
   localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } sync_t;

   function automatic sync_t decode_sync(input logic [9:0] x, input logic [9:0] y);
      sync_t s;
      s.hsync    = !((x >= H_SYNC_FIRST) && (x <= H_SYNC_LAST));
      s.vsync    = !((y >= V_SYNC_FIRST) && (y <= V_SYNC_LAST));
      s.video_on = (x < H_ACT_END) && (y < V_ACT_END);
      return s;
   endfunction

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - pixel-rate clock enable divider
//    clk   : system clock, rising edge
//    rst_n : asynchronous active-low reset
//    en    : registered one-clk strobe, high while the divider sits at CLK_DIV-1
module clk_en_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic en
);

   localparam int              CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]   DIV_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_q, div_d;
   logic          en_q, en_d;

   always_comb begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      // Strobe is registered from the next divider value so it lines up with
      // the clk in which the divider holds CLK_DIV-1 and is 0 during reset.
      en_d  = (div_d == DIV_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         en_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         en_q  <= en_d;
      end
   end

   assign en = en_q;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing generator with per-frame select latch
//    clk, rst_n   : system clock (rising edge), asynchronous active-low reset
//    select_in    : live note-period code
//    pix_en       : one-clk pixel strobe (every CLK_DIV clks)
//    x_counter    : pixel position 0..799, y_counter : line position 0..524
//    hsync, vsync : active-low syncs, video_on : inside 640x480 active area
//    frame_start  : one-clk pulse as the counters wrap to (0,0)
//    select_out   : select_in captured at frame_start, stable for the frame
module vga_sync_gen #(
   parameter int CLK_DIV = 4,
   parameter int SEL_W   = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEL_W-1:0] select_in,
   output logic             pix_en,
   output logic [9:0]       x_counter,
   output logic [9:0]       y_counter,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic             frame_start,
   output logic [SEL_W-1:0] select_out
);
   import vga_timing_pkg::*;

   logic [9:0]       x_q, x_d, y_q, y_d;
   logic             hs_q, hs_d, vs_q, vs_d, vo_q, vo_d, fs_q, fs_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   sync_t            sync_nxt;

   clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pix_en)
   );

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      hs_d     = hs_q;
      vs_d     = vs_q;
      vo_d     = vo_q;
      fs_d     = 1'b0;
      sync_nxt = '0;
      if (pix_en) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
         // Decode from the next position so syncs move with the counters.
         sync_nxt = decode_sync(x_d, y_d);
         hs_d     = sync_nxt.hsync;
         vs_d     = sync_nxt.vsync;
         vo_d     = sync_nxt.video_on;
         fs_d     = (x_q == H_LAST) && (y_q == V_LAST);
      end
      // Only the frame wrap may update the select, so a frame never tears.
      sel_d = fs_d ? select_in : sel_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q   <= '0;
         y_q   <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         vo_q  <= 1'b1;
         fs_q  <= 1'b0;
         sel_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         vo_q  <= vo_d;
         fs_q  <= fs_d;
         sel_q <= sel_d;
      end
   end

   assign x_counter   = x_q;
   assign y_counter   = y_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign video_on    = vo_q;
   assign frame_start = fs_q;
   assign select_out  = sel_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen
module tb_vga_sync_gen;

   localparam int D  = 4;
   localparam int SW = 18;
   localparam int FRAME_PIX = 800 * 525;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [SW-1:0] select_in;
   logic          pix_en, hsync, vsync, video_on, frame_start;
   logic [9:0]    x_counter, y_counter;
   logic [SW-1:0] select_out;

   vga_sync_gen #(.CLK_DIV(D), .SEL_W(SW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .select_in   (select_in),
      .pix_en      (pix_en),
      .x_counter   (x_counter),
      .y_counter   (y_counter),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .frame_start (frame_start),
      .select_out  (select_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: absolute pixel index since the last reposition, edge count since reset.
   int            n;
   int            p_base;
   int            pcnt;
   bit            valid;
   bit            fs_exp;
   bit            rand_sel;
   logic [SW-1:0] sel_exp;
   logic [SW-1:0] sel_prev;
   logic [9:0]    fxv, fyv;

   typedef struct {
      int fx, fy, npix;
      int ex, ey, fs, hs_low, vs_low, vo_on, hs_first;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int cur_p();
      return (p_base + pcnt) % FRAME_PIX;
   endfunction

   task automatic check_outputs();
      int p, ex, ey;
      p  = cur_p();
      ex = p % 800;
      ey = p / 800;
      chk("pix_en", int'(pix_en), int'(n % D == D - 1));
      chk("x_counter", int'(x_counter), ex);
      chk("y_counter", int'(y_counter), ey);
      chk("frame_start", int'(frame_start), int'(fs_exp));
      chk("select_out", int'(select_out), int'(sel_exp));
      if (valid) begin
         chk("hsync", int'(hsync), int'(!(ex >= 656 && ex <= 751)));
         chk("vsync", int'(vsync), int'(!(ey == 490 || ey == 491)));
         chk("video_on", int'(video_on), int'(ex < 640 && ey < 480));
      end
   endtask

   task automatic step();
      sel_prev = select_in;
      @(posedge clk);
      n++;
      fs_exp = 1'b0;
      if (n % D == 0) begin
         pcnt++;
         valid = 1'b1;
         if (cur_p() == 0) begin
            fs_exp  = 1'b1;
            sel_exp = sel_prev;
         end
      end
      @(negedge clk);
      check_outputs();
      if (rand_sel) select_in = SW'($urandom);
   endtask

   task automatic model_reset();
      n = 0; p_base = 0; pcnt = 0; valid = 1'b1; fs_exp = 1'b0; sel_exp = '0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pix_en"}, int'(pix_en), 0);
      chk({tag, "_x"}, int'(x_counter), 0);
      chk({tag, "_y"}, int'(y_counter), 0);
      chk({tag, "_hsync"}, int'(hsync), 1);
      chk({tag, "_vsync"}, int'(vsync), 1);
      chk({tag, "_video_on"}, int'(video_on), 1);
      chk({tag, "_frame_start"}, int'(frame_start), 0);
      chk({tag, "_select_out"}, int'(select_out), 0);
   endtask

   // Repositions the counters mid-clock so long spans (frame wrap, vsync) stay cheap to reach.
   task static jump(input int fx, input int fy);
      fxv = 10'(fx);
      fyv = 10'(fy);
      force dut.x_q = fxv;
      force dut.y_q = fyv;
      #1;
      release dut.x_q;
      release dut.y_q;
      p_base = fy * 800 + fx;
      pcnt   = 0;
      valid  = 1'b0;
   endtask

   task automatic first_pix_seq(input string tag);
      for (int k = 1; k <= 3 * D; k++) begin
         step();
         chk({tag, "_pix_en_edge"}, int'(pix_en), int'(k % D == D - 1));
         if (k == D) chk({tag, "_x_after_first_pix"}, int'(x_counter), 1);
      end
   endtask

   initial begin
      tbl[0] = '{790,  10,   20,  10,  11, 0,   0,    0,  11,  -1};
      tbl[1] = '{640, 100,  130, 770, 100, 0,  96,    0,   0, 656};
      tbl[2] = '{799, 489, 1602,   1, 492, 0, 192, 1600,   0, 656};
      tbl[3] = '{790, 524,   20,  10,   0, 1,   0,    0,  11,  -1};
      tbl[4] = '{630, 479,   20, 650, 479, 0,   0,    0,   9,  -1};
      tbl[5] = '{  0,  20,  800,   0,  21, 0,  96,    0, 640, 656};

      rand_sel  = 1'b0;
      select_in = '0;
      rst_n     = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      #1 check_reset_vals("por");
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("por_held");
      rst_n = 1'b1;
      model_reset();

      first_pix_seq("rel1");

      rand_sel = 1'b1;
      for (int v = 0; v < 6; v++) begin
         int fs_cnt, hs_cnt, vs_cnt, vo_cnt, hs_first;
         fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; vo_cnt = 0; hs_first = -1;
         jump(tbl[v].fx, tbl[v].fy);
         for (int k = 0; k < tbl[v].npix * D; k++) begin
            step();
            if (frame_start) fs_cnt++;
            if (n % D == 0) begin
               if (!hsync) begin
                  hs_cnt++;
                  if (hs_first < 0) hs_first = int'(x_counter);
               end
               if (!vsync) vs_cnt++;
               if (video_on) vo_cnt++;
            end
         end
         chk($sformatf("vec%0d_end_x", v), int'(x_counter), tbl[v].ex);
         chk($sformatf("vec%0d_end_y", v), int'(y_counter), tbl[v].ey);
         chk($sformatf("vec%0d_frame_starts", v), fs_cnt, tbl[v].fs);
         chk($sformatf("vec%0d_hsync_low_pix", v), hs_cnt, tbl[v].hs_low);
         chk($sformatf("vec%0d_vsync_low_pix", v), vs_cnt, tbl[v].vs_low);
         chk($sformatf("vec%0d_video_on_pix", v), vo_cnt, tbl[v].vo_on);
         chk($sformatf("vec%0d_hsync_first_x", v), hs_first, tbl[v].hs_first);
      end

      // Asynchronous reset in the middle of a frame, between edges.
      rand_sel = 1'b0;
      jump(300, 200);
      repeat (3 * D) step();
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      check_reset_vals("midrst_held");
      rst_n = 1'b1;
      model_reset();
      first_pix_seq("rel2");

      // Select latch holds through the frame and updates only at frame_start.
      select_in = '0;
      repeat (2 * D) step();
      jump(300, 200);
      select_in = SW'(95556);
      repeat (50 * D) step();
      chk("sel_mid_frame_a", int'(select_out), 0);
      jump(790, 524);
      repeat (20 * D) step();
      chk("sel_after_wrap_a", int'(select_out), 95556);
      jump(5, 5);
      select_in = SW'(47778);
      repeat (20 * D) step();
      chk("sel_mid_frame_b", int'(select_out), 95556);
      jump(795, 524);
      repeat (10 * D) step();
      chk("sel_after_wrap_b", int'(select_out), 47778);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: system clocks per pixel (100 MHz to 25 MHz pixel rate).
REQ-002 SHALL have parameter SEL_W, default 18: width of the note-select word.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port select_in, input, SEL_W: live note-period code from the keyboard/tone logic.
REQ-006 SHALL have port pix_en, output, 1: one-clk pixel strobe.
REQ-007 SHALL have port x_counter, output, 10: horizontal pixel position, 0..799.
REQ-008 SHALL have port y_counter, output, 10: vertical line position, 0..524.
REQ-009 SHALL have port hsync, output, 1: active-low horizontal sync.
REQ-010 SHALL have port vsync, output, 1: active-low vertical sync.
REQ-011 SHALL have port video_on, output, 1: high inside the 640x480 active area.
REQ-012 SHALL have port frame_start, output, 1: one-clk pulse at frame origin.
REQ-013 SHALL have port select_out, output, SEL_W: select_in sampled once per frame, driving the downstream pixel/RGB stage.

Function
REQ-014 SHALL count clocks 0..CLK_DIV-1 in a divider and assert pix_en for exactly the one clk in which the divider equals CLK_DIV-1; CLK_DIV=1 gives pix_en constantly high after reset.
REQ-015 SHALL change x_counter, y_counter, hsync, vsync, video_on and frame_start only in clks where pix_en is high; otherwise they hold (frame_start returns to 0 in the next clk).
REQ-016 SHALL increment x_counter on each pix_en; 799 wraps to 0.
REQ-017 SHALL increment y_counter when x_counter wraps; 524 wraps to 0 when x and y wrap together.
REQ-018 SHALL register hsync, vsync and video_on in the same clk as the counters, decoded from the new counter values, so all outputs agree with zero skew.
REQ-019 SHALL drive hsync low iff x_counter is in 656..751 (front porch 16, sync 96, back porch 48).
REQ-020 SHALL drive vsync low iff y_counter is in 490..491 (front porch 10, sync 2, back porch 33).
REQ-021 SHALL drive video_on high iff x_counter<640 and y_counter<480.
REQ-022 SHALL pulse frame_start high for exactly one clk, the clk in which the counters move from (799,524) to (0,0).
REQ-023 SHALL load select_out from select_in in the frame_start clk only; mid-frame changes of select_in SHALL NOT reach select_out, preventing image tearing.
REQ-024 SHALL keep all counter arithmetic at 10 bits with explicit compare-and-wrap and no reliance on overflow.

Reset
REQ-025 SHALL, while rst_n is low and independent of clk, force divider=0, pix_en=0, x_counter=0, y_counter=0, hsync=1, vsync=1, video_on=1, frame_start=0, select_out=0.
REQ-026 SHALL apply REQ-025 immediately on assertion mid-frame; after release the first pix_en SHALL occur on the CLK_DIV-th rising edge.

Structure
REQ-027 SHALL take all 640x480@60 timing constants (active, porches, sync widths, totals) from shared package vga_timing_pkg, which downstream pixel stages also use.
REQ-028 SHALL implement the divider as sub-module clk_en_div (params CLK_DIV; ports clk, rst_n, en); no derived clocks.

Verification
REQ-029 Reset release with CLK_DIV=4 -> pix_en high on the 4th edge, then every 4th; x_counter=1 after the first pix_en.
REQ-030 Run through x=799 at y=10 -> next pix_en gives x=0, y=11; hsync low for exactly 96 consecutive pix_en, starting when x=656.
REQ-031 Run through (799,524) -> (0,0) with frame_start high for one clk; vsync low exactly for y=490 and 491 (1600 pix_en); 420000 pix_en and 1680000 clk per frame.
REQ-032 Change select_in 0 -> 95556 at (300,200) -> select_out stays 0 until the frame_start clk, then becomes 95556; a further change to 47778 at (5,5) reaches select_out only at the next frame_start.
REQ-033 Assert rst_n low at (300,200) between clock edges -> all outputs take REQ-025 values before the next edge; after release, REQ-029 repeats.
REQ-034 Across a full frame, video_on high for exactly 307200 pix_en, never when x>=640 or y>=480.
